// File: rtl/a2d_seq_pkg.sv
// Shared types and widths for the dual sin/cos SAR A2D conversion sequencer.
package a2d_seq_pkg;

  localparam int unsigned SAR_W = 12;
  localparam int unsigned CNT_W = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STRT    = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    CAPT    = 3'd4,
    GAP     = 3'd5
  } seq_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/a2d_avg_acc.sv
// Per-channel sample accumulator/divider for the A2D sequencer.
// Present only when A2D_AVG_EN is defined; groups of 2^AVG_LOG2 samples, truncating average.
`ifdef A2D_AVG_EN
module a2d_avg_acc
  import a2d_seq_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add,
  input  logic             clr,
  input  logic [SAR_W-1:0] sin_in,
  input  logic [SAR_W-1:0] cos_in,
  output logic             last,
  output logic [SAR_W-1:0] sin_avg,
  output logic [SAR_W-1:0] cos_avg
);

  localparam int unsigned ACC_W = SAR_W + AVG_LOG2;

  logic [ACC_W-1:0]    sin_acc, cos_acc;
  logic [ACC_W-1:0]    sin_sum, cos_sum;
  logic [AVG_LOG2-1:0] cnt;

  // Average is taken from the sum including the sample being added, so the
  // result is ready on the same edge that the last sample arrives.
  assign last    = (cnt == '1);
  assign sin_sum = sin_acc + ACC_W'(sin_in);
  assign cos_sum = cos_acc + ACC_W'(cos_in);
  assign sin_avg = sin_sum[ACC_W-1:AVG_LOG2];
  assign cos_avg = cos_sum[ACC_W-1:AVG_LOG2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_acc <= '0;
      cos_acc <= '0;
      cnt     <= '0;
    end else if (clr) begin
      sin_acc <= '0;
      cos_acc <= '0;
      cnt     <= '0;
    end else if (add) begin
      cnt <= cnt + 1'b1;
      if (last) begin
        sin_acc <= '0;
        cos_acc <= '0;
      end else begin
        sin_acc <= sin_sum;
        cos_acc <= cos_sum;
      end
    end
  end

endmodule
`endif

// File: rtl/a2d_conv_sequencer.sv
// Conversion initiator for the dual sin/cos SAR A2D: free-run or single-shot, with timeout.
// Optional sample averaging is built when A2D_AVG_EN is defined.
module a2d_conv_sequencer
  import a2d_seq_pkg::*;
#(
  parameter int unsigned STRT_W   = 4,
  parameter int unsigned PERIOD   = 2048,
  parameter int unsigned TO_CYC   = 4095
`ifdef A2D_AVG_EN
  ,
  parameter int unsigned AVG_LOG2 = 2
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        trig,
  input  logic        cnv_cmplt,
  input  logic [11:0] sinSAR,
  input  logic [11:0] cosSAR,
  output logic        strt_cnv,
  output logic [11:0] sin_q,
  output logic [11:0] cos_q,
  output logic        smp_vld,
  output logic        busy,
  output logic        to_err
);

  localparam logic [CNT_W-1:0] STRT_LAST = CNT_W'(STRT_W - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);

  seq_state_t       state, nxt;
  logic [CNT_W-1:0] scnt, pcnt, tcnt;
  logic             cnv_s;
  logic             capt_now;
  logic             to_hit;
  logic             strt_entry;
  logic             waiting;

  assign strt_cnv   = (state == STRT);
  assign busy       = (state != IDLE);
  assign strt_entry = (nxt == STRT) && (state != STRT);
  assign waiting    = (state == WAIT_LO) || (state == WAIT_HI);

  always_comb begin
    nxt      = state;
    capt_now = 1'b0;
    to_hit   = 1'b0;
    case (state)
      IDLE:    if (run || trig) nxt = STRT;
      STRT:    if (scnt == STRT_LAST) nxt = WAIT_LO;
      WAIT_LO: begin
        if (!cnv_s) begin
          nxt = WAIT_HI;
        end else if (tcnt == TO_LAST) begin
          to_hit = 1'b1;
          nxt    = IDLE;
        end
      end
      WAIT_HI: begin
        if (cnv_s) begin
          capt_now = 1'b1;
          nxt      = CAPT;
        end else if (tcnt == TO_LAST) begin
          to_hit = 1'b1;
          nxt    = IDLE;
        end
      end
      CAPT:    nxt = run ? GAP : IDLE;
      GAP: begin
        if (!run)                  nxt = IDLE;
        else if (pcnt >= PER_LAST) nxt = STRT;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      scnt   <= '0;
      pcnt   <= '0;
      tcnt   <= '0;
      cnv_s  <= 1'b0;
      to_err <= 1'b0;
    end else begin
      state <= nxt;
      cnv_s <= cnv_cmplt;
      scnt  <= (state == STRT) ? scnt + 1'b1 : '0;
      pcnt  <= strt_entry ? '0 : sat_inc(pcnt);
      // Timeout budget restarts for each cnv_cmplt edge being waited on.
      tcnt  <= (waiting && (nxt == state)) ? tcnt + 1'b1 : '0;
      if (to_hit)          to_err <= 1'b1;
      else if (strt_entry) to_err <= 1'b0;
    end
  end

  // Capture is registered on the edge leaving WAIT_HI, so sin_q/cos_q and
  // smp_vld are both valid during the CAPT cycle.
`ifdef A2D_AVG_EN
  logic             grp_last;
  logic             acc_clr;
  logic [SAR_W-1:0] avg_sin, avg_cos;

  assign acc_clr = to_hit || ((state == CAPT) && !run);

  a2d_avg_acc #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk    (clk),
    .rst_n  (rst_n),
    .add    (capt_now),
    .clr    (acc_clr),
    .sin_in (sinSAR),
    .cos_in (cosSAR),
    .last   (grp_last),
    .sin_avg(avg_sin),
    .cos_avg(avg_cos)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_q   <= '0;
      cos_q   <= '0;
      smp_vld <= 1'b0;
    end else begin
      smp_vld <= 1'b0;
      if (capt_now && grp_last) begin
        sin_q   <= avg_sin;
        cos_q   <= avg_cos;
        smp_vld <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_q   <= '0;
      cos_q   <= '0;
      smp_vld <= 1'b0;
    end else begin
      smp_vld <= 1'b0;
      if (capt_now) begin
        sin_q   <= sinSAR;
        cos_q   <= cosSAR;
        smp_vld <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_a2d_conv_sequencer.sv
// Self-checking bench for a2d_conv_sequencer: behavioural A2D model plus sample-level reference.
module tb_a2d_conv_sequencer;

  localparam int unsigned STRT_W = 4;
  localparam int unsigned PERIOD = 2048;
  localparam int unsigned TO_CYC = 4095;
`ifdef A2D_AVG_EN
  localparam int GRP = 4;
`else
  localparam int GRP = 1;
`endif
  localparam bit AVG = (GRP > 1);

  logic        clk = 1'b0;
  logic        rst_n, run, trig, cnv_cmplt;
  logic [11:0] sinSAR, cosSAR;
  logic        strt_cnv, smp_vld, busy, to_err;
  logic [11:0] sin_q, cos_q;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  a2d_conv_sequencer #(
    .STRT_W(STRT_W),
    .PERIOD(PERIOD),
    .TO_CYC(TO_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .trig     (trig),
    .cnv_cmplt(cnv_cmplt),
    .sinSAR   (sinSAR),
    .cosSAR   (cosSAR),
    .strt_cnv (strt_cnv),
    .sin_q    (sin_q),
    .cos_q    (cos_q),
    .smp_vld  (smp_vld),
    .busy     (busy),
    .to_err   (to_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- A2D behavioural model ----------------
  typedef struct { logic [11:0] s; logic [11:0] c; int lo; int hi; } cfg_t;
  typedef struct { int at; logic [11:0] s; logic [11:0] c; } pend_t;

  cfg_t  cfg_q[$];
  cfg_t  cur = '{12'h0, 12'h0, 3, 100};
  pend_t pend_q[$];
  int    a2d_ph = 0;
  int    a2d_cnt = 0;
  bit    never_accept = 1'b0;

  initial begin
    cnv_cmplt = 1'b1;
    sinSAR    = '0;
    cosSAR    = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        a2d_ph    = 0;
        cnv_cmplt = 1'b1;
      end else begin
        case (a2d_ph)
          0: if (strt_cnv) begin
            if (cfg_q.size() != 0) cur = cfg_q.pop_front();
            a2d_cnt = cur.lo;
            a2d_ph  = 1;
          end
          1: if (!never_accept) begin
            a2d_cnt--;
            if (a2d_cnt <= 0) begin
              cnv_cmplt = 1'b0;
              a2d_cnt   = cur.hi;
              a2d_ph    = 2;
            end
          end
          2: begin
            a2d_cnt--;
            if (a2d_cnt <= 0) begin
              cnv_cmplt = 1'b1;
              sinSAR    = cur.s;
              cosSAR    = cur.c;
              // Sync flop + capture cycle: result visible two cycles after the rise.
              pend_q.push_back('{cyc + 2, cur.s, cur.c});
              a2d_ph    = 3;
            end
          end
          default: if (!strt_cnv) a2d_ph = 0;
        endcase
      end
    end
  end

  // ---------------- Reference model / monitor ----------------
  logic [11:0] grp_s[$];
  logic [11:0] grp_c[$];
  int          strt_rises[$];
  int          strt_w = 0;
  int          smp_cnt = 0;
  int          discard_at = -1;
  logic [11:0] exp_sin_q = '0;
  logic [11:0] exp_cos_q = '0;
  pend_t       p_cur;
  int          sum_s, sum_c;
  bit          exp_v;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        strt_w = 0;
      end else begin
        if (strt_cnv) begin
          if (strt_w == 0) strt_rises.push_back(cyc);
          strt_w++;
        end else if (strt_w != 0) begin
          chk("strt_width", strt_w, STRT_W);
          strt_w = 0;
        end
        if (cyc == discard_at && !run) begin
          grp_s.delete();
          grp_c.delete();
        end
        if (pend_q.size() != 0 && pend_q[0].at == cyc) begin
          p_cur = pend_q.pop_front();
          grp_s.push_back(p_cur.s);
          grp_c.push_back(p_cur.c);
          exp_v = 1'b0;
          if (grp_s.size() == GRP) begin
            sum_s = 0;
            sum_c = 0;
            foreach (grp_s[k]) begin
              sum_s += int'(grp_s[k]);
              sum_c += int'(grp_c[k]);
            end
            exp_sin_q = 12'(sum_s / GRP);
            exp_cos_q = 12'(sum_c / GRP);
            exp_v     = 1'b1;
            grp_s.delete();
            grp_c.delete();
          end
          discard_at = cyc + 1;
          chk("smp_vld", smp_vld, exp_v);
          if (exp_v) begin
            chk("sin_q", sin_q, exp_sin_q);
            chk("cos_q", cos_q, exp_cos_q);
          end
        end else if (smp_vld) begin
          chk("smp_vld_unexpected", smp_vld, 1'b0);
        end
        if (smp_vld) smp_cnt++;
      end
    end
  end

  task automatic pulse_trig();
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_rises(input int target, input int budget);
    int n = 0;
    while (strt_rises.size() < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- Stimulus ----------------
  typedef struct { logic [11:0] s; logic [11:0] c; int lo; int hi; logic [11:0] es; logic [11:0] ec; } vec_t;
  vec_t vecs[4];
  int   r0, n0, s0;
  cfg_t fr_cfg[5];

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    trig  = 1'b0;

    // Single-shot: in the averaging build each lone sample is discarded (run=0 at CAPT).
    vecs[0] = '{12'hA5C, 12'h3F1, 3, 1700, AVG ? 12'h000 : 12'hA5C, AVG ? 12'h000 : 12'h3F1};
    vecs[1] = '{12'hFFF, 12'h000, 1,   10, AVG ? 12'h000 : 12'hFFF, AVG ? 12'h000 : 12'h000};
    vecs[2] = '{12'h000, 12'hFFF, 6,   40, AVG ? 12'h000 : 12'h000, AVG ? 12'h000 : 12'hFFF};
    vecs[3] = '{12'h5A5, 12'hA5A, 2,  300, AVG ? 12'h000 : 12'h5A5, AVG ? 12'h000 : 12'hA5A};

    #1;
    chk("rst_strt_cnv", strt_cnv, 1'b0);
    chk("rst_sin_q", sin_q, 12'h000);
    chk("rst_cos_q", cos_q, 12'h000);
    chk("rst_smp_vld", smp_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_to_err", to_err, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      cfg_q.push_back('{vecs[i].s, vecs[i].c, vecs[i].lo, vecs[i].hi});
      r0 = strt_rises.size();
      n0 = smp_cnt;
      pulse_trig();
      chk("tbl_busy", busy, 1'b1);
      if (i == 1 || i == 3) begin
        repeat (8) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
      end
      wait_idle(5000, "tbl");
      chk("tbl_sin_q", sin_q, vecs[i].es);
      chk("tbl_cos_q", cos_q, vecs[i].ec);
      chk("tbl_smp_cnt", smp_cnt - n0, AVG ? 0 : 1);
      chk("tbl_one_start", strt_rises.size() - r0, 1);
      repeat (4) @(negedge clk);
    end

    // Timeout in WAIT_LO.
    never_accept = 1'b1;
    r0 = strt_rises.size();
    n0 = smp_cnt;
    pulse_trig();
    wait_rises(r0 + 1, 20);
    s0 = (strt_rises.size() > r0) ? strt_rises[r0] : cyc;
    while (cyc < s0 + int'(STRT_W) + int'(TO_CYC) - 1) begin
      @(posedge clk); #1;
    end
    chk("to_err_before", to_err, 1'b0);
    chk("to_busy_before", busy, 1'b1);
    @(posedge clk); #1;
    chk("to_err_set", to_err, 1'b1);
    chk("to_busy_after", busy, 1'b0);
    chk("to_no_smp", smp_cnt - n0, 0);
    grp_s.delete();
    grp_c.delete();
    @(negedge clk);
    never_accept = 1'b0;
    a2d_ph       = 0;
    repeat (5) @(negedge clk);
    chk("to_err_sticky", to_err, 1'b1);
    cfg_q.push_back('{12'h7E1, 12'h18C, 3, 100});
    pulse_trig();
    chk("to_err_cleared", to_err, 1'b0);
    chk("to_restart_strt", strt_cnv, 1'b1);
    wait_idle(500, "to_recover");
    chk("to_recover_sin", sin_q, AVG ? 12'h000 : 12'h7E1);

    // Reset during WAIT_HI.
    cfg_q.push_back('{12'h123, 12'h456, 3, 1700});
    pulse_trig();
    repeat (50) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_sin", sin_q, exp_sin_q);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strt", strt_cnv, 1'b0);
    chk("mid_rst_smp", smp_vld, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_sin", sin_q, 12'h000);
    chk("mid_rst_cos", cos_q, 12'h000);
    pend_q.delete();
    grp_s.delete();
    grp_c.delete();
    exp_sin_q = '0;
    exp_cos_q = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Free-run with fixed samples; run and trig raised together.
    fr_cfg[0] = '{12'h100, 12'h200, 3, 1700};
    fr_cfg[1] = '{12'h101, 12'h204, 3, 1700};
    fr_cfg[2] = '{12'h102, 12'h208, 3, 1700};
    fr_cfg[3] = '{12'h105, 12'h20F, 3, 1700};
    fr_cfg[4] = '{12'h0F0, 12'h300, 3, 1700};
    foreach (fr_cfg[k]) cfg_q.push_back(fr_cfg[k]);
    r0 = strt_rises.size();
    n0 = smp_cnt;
    @(negedge clk);
    run  = 1'b1;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_rises(r0 + 5, 12000);
    chk("fr_starts", strt_rises.size() - r0, 5);
    @(negedge clk);
    run = 1'b0;
    wait_idle(4000, "fr");
    if (strt_rises.size() >= r0 + 5) begin
      for (int k = 1; k < 5; k++)
        chk("fr_period", strt_rises[r0 + k] - strt_rises[r0 + k - 1], PERIOD);
    end
    chk("fr_no_extra", strt_rises.size() - r0, 5);
    chk("fr_smp_cnt", smp_cnt - n0, AVG ? 1 : 5);
    chk("fr_sin_q", sin_q, AVG ? 12'h102 : 12'h0F0);
    chk("fr_cos_q", cos_q, AVG ? 12'h206 : 12'h300);
    repeat (5) @(negedge clk);

    // Free-run with randomised data and A2D timing.
    for (int k = 0; k < 6; k++)
      cfg_q.push_back('{12'($urandom), 12'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(20, 1900))});
    r0 = strt_rises.size();
    @(negedge clk);
    run = 1'b1;
    wait_rises(r0 + 6, 14000);
    chk("rnd_starts", strt_rises.size() - r0, 6);
    @(negedge clk);
    run = 1'b0;
    wait_idle(4000, "rnd");
    if (strt_rises.size() >= r0 + 6) begin
      for (int k = 1; k < 6; k++)
        chk("rnd_period", strt_rises[r0 + k] - strt_rises[r0 + k - 1], PERIOD);
    end
    chk("rnd_sin_hold", sin_q, exp_sin_q);
    chk("rnd_cos_hold", cos_q, exp_cos_q);
    chk("rnd_pend_empty", pend_q.size(), 0);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
